// File: rtl/melody_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// melody_sequencer_pkg : FSM states and score word layout (GAP under NOTE_GAP_EN) -- rev 1.0
// ---------------------------------------------------------------------------
package melody_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_PLAY  = 3'd2,
`ifdef NOTE_GAP_EN
      S_GAP   = 3'd3,
`endif
      S_END   = 3'd4
   } state_t;

   localparam int NOTE_LSB = 12;
   localparam int OCT_LSB  = 8;
   localparam int DUR_LSB  = 0;

   // A zero duration marks the end of the score.
   localparam logic [7:0] END_DUR = 8'd0;

   function automatic logic [3:0] score_note(input logic [15:0] w);
      return w[NOTE_LSB +: 4];
   endfunction

   function automatic logic [3:0] score_octave(input logic [15:0] w);
      return w[OCT_LSB +: 4];
   endfunction

   function automatic logic [7:0] score_dur(input logic [15:0] w);
      return w[DUR_LSB +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/melody_sequencer_tick_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_divider : free-running prescaler, one-cycle tick every TICK_DIV cycles -- rev 1.0
// ---------------------------------------------------------------------------
module tick_divider #(
   parameter int TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Tick is suppressed while cleared so a fresh interval always spans TICK_DIV cycles.
   always_comb begin
      tick = !clear && (cnt_q == CNT_MAX);
      if (clear || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// melody_sequencer : score ROM player driving note/octave; NOTE_GAP_EN adds a silent tick between notes -- rev 1.0
// ---------------------------------------------------------------------------
module melody_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int TICK_DIV = 5000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] score_addr,
   input  logic [15:0]       score_data,
   output logic [3:0]        note,
   output logic [3:0]        octave,
   output logic              busy,
   output logic              done
);

   import melody_sequencer_pkg::*;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
`ifdef NOTE_GAP_EN
   localparam state_t AFTER_PLAY = S_GAP;
`else
   localparam state_t AFTER_PLAY = S_FETCH;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        note_q, note_d;
   logic [3:0]        oct_q, oct_d;
   logic [7:0]        dur_q, dur_d;
   logic [7:0]        dcnt_q, dcnt_d;
   logic              tick;
   logic              presc_clear;
   logic              play_last;
   logic [3:0]        rom_note, rom_oct;
   logic [7:0]        rom_dur;

   assign rom_note = score_note(score_data);
   assign rom_oct  = score_octave(score_data);
   assign rom_dur  = score_dur(score_data);

   assign play_last = (state_q == S_PLAY) && tick && (dcnt_q == dur_q - 8'd1);

`ifdef NOTE_GAP_EN
   assign presc_clear = (state_q != S_PLAY) && (state_q != S_GAP);
`else
   assign presc_clear = (state_q != S_PLAY);
`endif

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (presc_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         note_q  <= 4'd0;
         oct_q   <= 4'd0;
         dur_q   <= 8'd0;
         dcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         dur_q   <= dur_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q != S_IDLE) && stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start && !stop) state_d = S_FETCH;
            S_FETCH: state_d = (rom_dur == END_DUR) ? S_END : S_PLAY;
            // The last address ends the score rather than wrapping to 0.
            S_PLAY:  if (play_last) state_d = (addr_q == ADDR_LAST) ? S_END : AFTER_PLAY;
`ifdef NOTE_GAP_EN
            S_GAP:   if (tick) state_d = S_FETCH;
`endif
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      done   = (state_q == S_END);
      addr_d = addr_q;
      note_d = note_q;
      oct_d  = oct_q;
      dur_d  = dur_q;
      dcnt_d = dcnt_q;
      if (state_d == S_IDLE) begin
         addr_d = '0;
         note_d = 4'd0;
         oct_d  = 4'd0;
         dur_d  = 8'd0;
         dcnt_d = 8'd0;
      end else if (state_d == S_END) begin
         note_d = 4'd0;
         oct_d  = 4'd0;
      end else begin
         // Pitch holds through FETCH; it is only replaced when the next note starts.
         case (state_q)
            S_FETCH: begin
               note_d = rom_note;
               oct_d  = rom_oct;
               dur_d  = rom_dur;
               dcnt_d = 8'd0;
            end
            S_PLAY: begin
               if (tick) dcnt_d = dcnt_q + 8'd1;
               if (play_last) begin
                  addr_d = addr_q + ADDR_W'(1);
`ifdef NOTE_GAP_EN
                  note_d = 4'd0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign score_addr = addr_q;
   assign note       = note_q;
   assign octave     = oct_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_melody_sequencer : randomized bench against a per-cycle timeline model -- rev 1.0
// ---------------------------------------------------------------------------
module tb_melody_sequencer;

   localparam int ADDR_W   = 3;
   localparam int TICK_DIV = 4;
   localparam int DEPTH    = 1 << ADDR_W;
`ifdef NOTE_GAP_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [ADDR_W-1:0] score_addr;
   logic [15:0]       score_data;
   logic [3:0]        note;
   logic [3:0]        octave;
   logic              busy;
   logic              done;
   logic [15:0]       rom [DEPTH];

   assign score_data = rom[score_addr];
   always #5 clk = ~clk;

   melody_sequencer #(
      .ADDR_W   (ADDR_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .score_addr (score_addr),
      .score_data (score_data),
      .note       (note),
      .octave     (octave),
      .busy       (busy),
      .done       (done)
   );

   typedef struct packed {
      logic [3:0]        n;
      logic [3:0]        o;
      logic [ADDR_W-1:0] a;
      logic              b;
      logic              d;
   } obs_t;

   localparam obs_t IDLE_OBS = '0;

   obs_t tl[$];
   obs_t cur = '0;
   int   checks = 0;
   int   errors = 0;

   function automatic obs_t mk(input logic [3:0] n, input logic [3:0] o, input int a, input logic d);
      obs_t r;
      r.n = n; r.o = o; r.a = ADDR_W'(a); r.b = 1'b1; r.d = d;
      return r;
   endfunction

   // Whole playback expressed as the list of per-cycle outputs, from the score contents.
   function automatic void build_timeline();
      logic [3:0]  pn;
      logic [3:0]  po;
      logic [15:0] w;
      int          dur;
      pn = 4'd0;
      po = 4'd0;
      tl.delete();
      for (int a = 0; a < DEPTH; a++) begin
         w   = rom[a];
         dur = int'(w[7:0]);
         tl.push_back(mk(pn, po, a, 1'b0));
         if (dur == 0) begin
            tl.push_back(mk(4'd0, 4'd0, a, 1'b1));
            return;
         end
         for (int c = 0; c < dur * TICK_DIV; c++) tl.push_back(mk(w[15:12], w[11:8], a, 1'b0));
         pn = w[15:12];
         po = w[11:8];
         if (a == DEPTH - 1) begin
            tl.push_back(mk(4'd0, 4'd0, a, 1'b1));
            return;
         end
         for (int c = 0; c < GAP * TICK_DIV; c++) tl.push_back(mk(4'd0, po, a + 1, 1'b0));
         if (GAP != 0) pn = 4'd0;
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      obs_t nxt;
      if (!rst_n) begin
         tl.delete();
         cur <= IDLE_OBS;
      end else begin
         nxt = IDLE_OBS;
         if (cur.b) begin
            if (!stop && tl.size() > 0) nxt = tl.pop_front();
            else tl.delete();
         end else if (start && !stop) begin
            build_timeline();
            nxt = tl.pop_front();
         end
         cur <= nxt;
      end
   end

   always @(negedge clk) begin : compare
      obs_t act;
      act = {note, octave, score_addr, busy, done};
      checks++;
      if (act !== cur) begin
         errors++;
         $display("FAIL model_cmp t=%0t actual note=%0d oct=%0d addr=%0d busy=%0b done=%0b required note=%0d oct=%0d addr=%0d busy=%0b done=%0b",
                  $time, act.n, act.o, act.a, act.b, act.d, cur.n, cur.o, cur.a, cur.b, cur.d);
      end
   end

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check_int("wait_idle", int'(busy), 0);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;
   endtask

   // Start a playback and measure it; index 1 is the cycle after the start cycle.
   task automatic play_run(input int restart_at, input logic [3:0] tgt,
                           output int busy_c, output int tgt_c, output int done_c,
                           output int first_tgt, output int done_addr, output int idle_addr);
      busy_c = 0; tgt_c = 0; done_c = 0; first_tgt = -1; done_addr = -1; idle_addr = -1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 1; i < 400; i++) begin
         @(negedge clk);
         start = (i == restart_at);
         if (busy) busy_c++;
         if (busy && note == tgt) begin
            tgt_c++;
            if (first_tgt < 0) first_tgt = i;
         end
         if (done) begin
            done_c++;
            done_addr = int'(score_addr);
         end
         if (!busy) begin
            idle_addr = int'(score_addr);
            break;
         end
      end
      start = 1'b0;
      check_int("play_terminates", int'(idle_addr >= 0), 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int bc, tc, dc, ft, da, ia, dcount;
      clear_rom();
      #12;
      check_int("reset_note", int'(note), 0);
      check_int("reset_busy", int'(busy), 0);
      check_int("reset_addr", int'(score_addr), 0);
      check_int("reset_done", int'(done), 0);
      #11 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Note then rest then end marker.
      rom[0] = 16'h1305; rom[1] = 16'h0002; rom[2] = 16'h0000;
      play_run(-1, 4'd1, bc, tc, dc, ft, da, ia);
      check_int("s1_busy_cycles", bc, 32 + 8 * GAP);
      check_int("s1_note1_cycles", tc, 21 - GAP);
      check_int("s1_first_note_idx", ft, 2);
      check_int("s1_done_pulses", dc, 1);
      check_int("s1_idle_addr", ia, 0);

      // Repeated identical notes: legato without gap, separated with gap.
      clear_rom();
      rom[0] = 16'h2401; rom[1] = 16'h2401; rom[2] = 16'h0000;
      play_run(-1, 4'd2, bc, tc, dc, ft, da, ia);
      check_int("s2_busy_cycles", bc, 12 + 8 * GAP);
      check_int("s2_note2_cycles", tc, 10 - 2 * GAP);
      check_int("s2_done_pulses", dc, 1);

      // Full score: ends at the last address, no wrap.
      for (int i = 0; i < DEPTH; i++) rom[i] = {4'(i + 1), 4'd2, 8'd1};
      play_run(-1, 4'd8, bc, tc, dc, ft, da, ia);
      check_int("s3_busy_cycles", bc, 41 + 28 * GAP);
      check_int("s3_done_pulses", dc, 1);
      check_int("s3_done_addr", da, DEPTH - 1);
      check_int("s3_idle_addr", ia, 0);
      check_int("s3_last_note_cycles", tc, TICK_DIV);

      // Stop three cycles into a note.
      clear_rom();
      rom[0] = 16'h1305; rom[1] = 16'h0002; rom[2] = 16'h0000;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      check_int("stop_note", int'(note), 0);
      check_int("stop_busy", int'(busy), 0);
      check_int("stop_addr", int'(score_addr), 0);
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check_int("stop_no_done", dcount, 0);
      play_run(-1, 4'd1, bc, tc, dc, ft, da, ia);
      check_int("replay_busy_cycles", bc, 32 + 8 * GAP);
      check_int("replay_first_note_idx", ft, 2);

      // start and stop together from idle.
      @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
      @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end
      @(negedge clk);
      check_int("startstop_busy", int'(busy), 0);

      // Extra start during PLAY leaves timing unchanged.
      play_run(6, 4'd1, bc, tc, dc, ft, da, ia);
      check_int("restart_busy_cycles", bc, 32 + 8 * GAP);
      check_int("restart_note1_cycles", tc, 21 - GAP);

      // Asynchronous reset mid-note.
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_int("arst_note", int'(note), 0);
      check_int("arst_octave", int'(octave), 0);
      check_int("arst_busy", int'(busy), 0);
      check_int("arst_addr", int'(score_addr), 0);
      check_int("arst_done", int'(done), 0);
      @(posedge clk); #3 rst_n = 1'b1;
      play_run(-1, 4'd1, bc, tc, dc, ft, da, ia);
      check_int("post_arst_busy_cycles", bc, 32 + 8 * GAP);
      check_int("post_arst_first_note_idx", ft, 2);
      check_int("post_arst_done_pulses", dc, 1);

      // Random scores with random start/stop pulses.
      for (int ep = 0; ep < 30; ep++) begin
         for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), d};
         end
         @(posedge clk); #1 start = 1'b1;
         for (int c = 0; c < 250; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 99) == 0);
         end
         start = 1'b0;
         stop  = 1'b0;
         wait_idle();
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 8, score address width.
REQ-002 TICK_DIV, 5000000, clock cycles per duration tick.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port start  input  1  one-cycle pulse; begin playback from address 0.
REQ-006 Port stop  input  1  one-cycle pulse; abort playback.
REQ-007 Port score_addr  output  ADDR_W  address into the combinational score ROM.
REQ-008 Port score_data  input  16  ROM word: [15:12] note, [11:8] octave, [7:0] duration in ticks.
REQ-009 Port note  output  4  pitch-stage note code; 0 = silence.
REQ-010 Port octave  output  4  pitch-stage octave code.
REQ-011 Port busy  output  1  high in any state other than IDLE.
REQ-012 Port done  output  1  one-cycle pulse on normal end of score.

Function
REQ-013 States SHALL be IDLE, FETCH, PLAY, GAP and END.
REQ-014 IDLE: note=0, score_addr=0; start moves the FSM to FETCH.
REQ-015 FETCH lasts exactly one cycle and samples score_data at score_addr.
REQ-016 FETCH with duration==0 SHALL go to END (end-of-score marker); otherwise it goes to PLAY, loading note, octave and the tick counter.
REQ-017 note and octave SHALL change only on FETCH->PLAY, END or IDLE entry, and hold their values during FETCH (no glitch between notes).
REQ-018 A score entry with note==0 is a rest: PLAY runs for its duration with note=0.
REQ-019 The tick prescaler SHALL clear on PLAY entry, so PLAY lasts exactly duration*TICK_DIV cycles.
REQ-020 Latency: start at cycle N -> FETCH at N+1 -> note valid at N+2.
REQ-021 On PLAY completion, score_addr SHALL increment, then the FSM goes to GAP (macro on) or FETCH (macro off).
REQ-022 Wrap-around: completing PLAY at score_addr == 2^ADDR_W-1 SHALL go to END instead of wrapping to 0.
REQ-023 END lasts one cycle: note=0, done=1, then the FSM goes to IDLE.
REQ-024 stop in any non-IDLE state SHALL force IDLE on the next edge: note=0, score_addr=0, no done pulse.
REQ-025 start while busy SHALL be ignored; if start and stop arrive in the same cycle, stop wins.
REQ-026 Duration counter is 8 bits and the prescaler is ceil(log2(TICK_DIV)) bits; neither overflows, since the FSM leaves PLAY at count==duration.

Reset
REQ-027 While rst_n=0: state=IDLE, note=0, octave=0, score_addr=0, busy=0, done=0, counters=0.
REQ-028 Reset asserted mid-note SHALL silence the output immediately (asynchronously), with no done pulse.
REQ-029 After release, the first start SHALL behave identically to a start issued after power-up.

Configuration
REQ-030 Macro NOTE_GAP_EN defined: GAP state holds note=0 for exactly one tick (TICK_DIV cycles) between notes, then goes to FETCH.
REQ-031 Macro undefined: the GAP state and its logic are not compiled, and PLAY goes directly to FETCH; consecutive identical notes then sound legato.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the score field bit positions and the END duration constant (0).
REQ-033 The tick prescaler SHALL be a sub-module, tick_divider (clk, rst_n, clear, tick), and is reusable by other timing stages.

Verification (TICK_DIV=4, ADDR_W=3)
REQ-034 ROM {0x1305, 0x0002, 0x0000}, start -> note=1/octave=3 for 20 cycles, rest for 8 cycles, done pulse, busy falls.
REQ-035 NOTE_GAP_EN, ROM {0x2401, 0x2401, 0x0000} -> note=2 for 4 cycles, note=0 for 4 cycles, note=2 for 4 cycles, then done.
REQ-036 stop 3 cycles into a note -> next cycle note=0, busy=0, score_addr=0, no done; a later start replays from address 0.
REQ-037 All 8 ROM entries nonzero with duration 1 -> 8 notes play, then END at address 7 with done, and no wrap to address 0.
REQ-038 start+stop in the same cycle from IDLE -> FSM stays in IDLE; start during PLAY -> note timing unchanged.
REQ-039 rst_n pulsed low mid-PLAY -> note=0 before the next clock edge, all outputs at reset values, and no done pulse.
